block_gather: RTL and testbench
===============================

Name: block_gather

Overview:
- Upstream feeder for the block highlight stage.
- Accepts a serial stream of words and packs every 16 words into one 4x4 frame: 4 blocks of 4 words each.
- Presents each completed frame as a one-cycle `blocks_valid_out` pulse, in the shape the highlight stage's `blocks` input expects.
- Two frame banks are used ping-pong, so a new frame can fill while the previous one waits for the downstream handshake.

Parameters:
- `WORD_SIZE`, 8, width of one word in bits.
- `CNT_WIDTH`, 16, width of the completed-frame counter.

Ports:
- `clk`  input  1  — the block's one clock.
- `rst`  input  1  — asynchronous, active-high reset.
- `word_in`  input  WORD_SIZE  — incoming word.
- `word_valid_in`  input  1  — `word_in` is valid this cycle.
- `word_last_in`  input  1  — qualified by `word_valid_in`; marks the final word of a frame (early termination allowed).
- `word_ready_out`  output  1  — block can accept a word this cycle.
- `blocks_out`  output  [3:0][3:0][WORD_SIZE-1:0]  — frame contents; `blocks_out[b][w]`.
- `blocks_valid_out`  output  1  — frame on `blocks_out` is valid.
- `blocks_ready_in`  input  1  — downstream accepts the frame; tie to 1 when feeding highlight directly.
- `frame_count_out`  output  CNT_WIDTH  — number of frames transferred downstream, wraps modulo 2^CNT_WIDTH.

Behaviour:
- Clock and reset: one clock `clk`; reset `rst` is asynchronous and active-high.
- Reset clears:
  - both banks to all-zero contents, both in state EMPTY;
  - `wr_bank`=0, `rd_bank`=0, `wr_idx`=0;
  - outputs `blocks_valid_out`=0, `blocks_out`=0, `frame_count_out`=0;
  - `word_ready_out`=1 from the first cycle after reset deasserts.
- Bank states: each bank is FILLING or FULL (EMPTY and FILLING are equivalent for writes).
- Write side:
  - `word_ready_out` = bank[`wr_bank`] not FULL.
  - Accept when `word_valid_in` && `word_ready_out`: bank[`wr_bank`][`wr_idx`[3:2]][`wr_idx`[1:0]] <= `word_in`.
  - Word order: `wr_idx` 0..3 fill block 0 words 0..3, `wr_idx` 4..7 fill block 1, and so on.
  - On accept with `wr_idx`==15 or `word_last_in`=1: mark bank FULL, `wr_idx`<=0, toggle `wr_bank`. Otherwise `wr_idx`++.
  - Early `last` leaves the remaining words of the bank at zero (banks are zero-cleared on release).
  - `word_last_in` without `word_valid_in` is ignored.
- Read side:
  - `blocks_valid_out` = bank[`rd_bank`] FULL; `blocks_out` = bank[`rd_bank`] contents (registered storage, mux output).
  - Transfer when `blocks_valid_out` && `blocks_ready_in`. On that edge: bank[`rd_bank`] <= all-zero and not FULL, toggle `rd_bank`, `frame_count_out`++.
  - With `blocks_ready_in`=1, `blocks_valid_out` is a one-cycle pulse per frame.
  - `blocks_out` and `blocks_valid_out` are stable while valid && !ready.
- Latency: the frame-completing word is accepted at edge N; `blocks_valid_out`=1 in the cycle after edge N. Words are never combinationally forwarded.
- Throughput: with `blocks_ready_in`=1, one word per cycle sustained indefinitely, with no gaps at frame boundaries.
- Simultaneous events:
  - A write completing one bank and a read releasing the other bank on the same edge are both performed.
  - A bank that becomes FULL is not readable until the next cycle.
  - If both banks are FULL, `word_ready_out`=0 until a transfer. Input then resumes in the cycle after the transfer edge, writing into the bank just released.
- Zero-length frame does not exist: `last` always comes with a stored word.
- Reset mid-frame (async): partial and full banks are discarded immediately, outputs drop to reset values without waiting for a clock edge, and no pulse is issued for discarded data.

Test Plan:
1. **Basic fill:** `rst` then words 0x00..0x0F, one per cycle, `blocks_ready_in`=1 -> one `blocks_valid_out` pulse the cycle after 0x0F accepted; `blocks_out[b][w]`=4*b+w; `frame_count_out`=1.
2. **Back-to-back frames:** 48 words 0x00..0x2F continuous, ready=1 -> `word_ready_out` stays 1 throughout; pulses 16 cycles apart; frame 3 `blocks_out[3][3]`=0x2F; `frame_count_out`=3.
3. **Backpressure:** `blocks_ready_in`=0 while streaming 40 words -> after word 32, `word_ready_out`=0 and the frame 1 data holds stable. Raise ready for one cycle -> frame 1 transfers and input resumes the next cycle; frame 2 then presents.
4. **Early last:** 6 words 0xA0..0xA5 with `last` on 0xA5 -> block0=A0..A3, block1=A4,A5,00,00, blocks 2/3 all 0x00; the following full frame is unaffected.
5. **Simultaneous events:** while frame A is held (ready=0) and the final word of frame B is being written, raise ready on that same edge -> A transfers, B becomes valid the next cycle, count +1 then +1.
6. **Async reset:** assert `rst` mid-frame (word 7) and while a frame is held -> outputs drop to 0 immediately; after release, 16 new words produce exactly one clean frame with `frame_count_out`=1.

Source files
------------

// File: rtl/block_gather.sv
// Packs a serial word stream into 4x4 frames (4 blocks of 4 words) for the block highlight stage.
// Two frame banks alternate so one can fill while the other waits for the downstream handshake.
module block_gather #(
  parameter int WORD_SIZE = 8,
  parameter int CNT_WIDTH = 16
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [WORD_SIZE-1:0]              word_in,
  input  logic                              word_valid_in,
  input  logic                              word_last_in,
  output logic                              word_ready_out,
  output logic [3:0][3:0][WORD_SIZE-1:0]    blocks_out,
  output logic                              blocks_valid_out,
  input  logic                              blocks_ready_in,
  output logic [CNT_WIDTH-1:0]              frame_count_out
);

  typedef enum logic [1:0] {
    BANK_EMPTY   = 2'd0,
    BANK_FILLING = 2'd1,
    BANK_FULL    = 2'd2
  } bank_state_t;

  bank_state_t                          bank_state [2];
  logic [1:0][3:0][3:0][WORD_SIZE-1:0]  bank_data;
  logic                                 wr_bank;
  logic                                 rd_bank;
  logic [3:0]                           wr_idx;

  logic wr_accept;
  logic wr_done;
  logic rd_xfer;

  // Handshakes come straight from registered bank state, so no input ever reaches an output combinationally.
  assign word_ready_out   = (bank_state[wr_bank] != BANK_FULL);
  assign blocks_valid_out = (bank_state[rd_bank] == BANK_FULL);
  assign blocks_out       = bank_data[rd_bank];

  assign wr_accept = word_valid_in && word_ready_out;
  assign wr_done   = wr_accept && ((wr_idx == 4'd15) || word_last_in);
  assign rd_xfer   = blocks_valid_out && blocks_ready_in;

  // A read only ever targets a FULL bank and a write a non-FULL one, so both can happen on the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bank_state[0]   <= BANK_EMPTY;
      bank_state[1]   <= BANK_EMPTY;
      bank_data       <= '0;
      wr_bank         <= 1'b0;
      rd_bank         <= 1'b0;
      wr_idx          <= 4'd0;
      frame_count_out <= '0;
    end else begin
      if (wr_accept) begin
        bank_data[wr_bank][wr_idx[3:2]][wr_idx[1:0]] <= word_in;
        if (wr_done) begin
          bank_state[wr_bank] <= BANK_FULL;
          wr_idx              <= 4'd0;
          wr_bank             <= ~wr_bank;
        end else begin
          bank_state[wr_bank] <= BANK_FILLING;
          wr_idx              <= wr_idx + 4'd1;
        end
      end
      // Released banks are zeroed so an early-terminated frame leaves its unused words at zero.
      if (rd_xfer) begin
        bank_data[rd_bank]  <= '0;
        bank_state[rd_bank] <= BANK_EMPTY;
        rd_bank             <= ~rd_bank;
        frame_count_out     <= frame_count_out + CNT_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_block_gather.sv
// Self-checking bench for block_gather: a frame scoreboard is filled as words are driven
// and drained as frames are handed downstream.
module tb_block_gather;

  typedef logic [3:0][3:0][7:0] frame_t;

  logic        clk;
  logic        rst;
  logic [7:0]  word_in;
  logic        word_valid_in;
  logic        word_last_in;
  logic        word_ready_out;
  frame_t      blocks_out;
  logic        blocks_valid_out;
  logic        blocks_ready_in;
  logic [15:0] frame_count_out;

  block_gather #(.WORD_SIZE(8), .CNT_WIDTH(16)) dut (
    .clk              (clk),
    .rst              (rst),
    .word_in          (word_in),
    .word_valid_in    (word_valid_in),
    .word_last_in     (word_last_in),
    .word_ready_out   (word_ready_out),
    .blocks_out       (blocks_out),
    .blocks_valid_out (blocks_valid_out),
    .blocks_ready_in  (blocks_ready_in),
    .frame_count_out  (frame_count_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  frame_t      exp_q[$];
  frame_t      build;
  logic [3:0]  build_idx;
  logic [15:0] model_count;

  logic        obs_ready, obs_valid, exp_ready, exp_valid, last_acc;
  frame_t      obs_blocks, exp_head;
  logic [15:0] obs_count, exp_cnt;

  task automatic reset_model();
    exp_q.delete();
    build       = '0;
    build_idx   = 4'd0;
    model_count = 16'd0;
  endtask

  // Called at a falling edge: samples outputs, advances the model, drives inputs, runs one clock.
  task automatic tick(input logic v, input logic [7:0] w, input logic l, input logic r);
    frame_t dummy;
    obs_ready  = word_ready_out;
    obs_valid  = blocks_valid_out;
    obs_blocks = blocks_out;
    obs_count  = frame_count_out;
    exp_ready  = (exp_q.size() < 2);
    exp_valid  = (exp_q.size() > 0);
    exp_head   = exp_valid ? exp_q[0] : '0;
    exp_cnt    = model_count;
    last_acc   = v && exp_ready;
    if (r && exp_valid) begin
      dummy = exp_q.pop_front();
      model_count = model_count + 16'd1;
    end
    if (last_acc) begin
      build[build_idx[3:2]][build_idx[1:0]] = w;
      if (build_idx == 4'd15 || l) begin
        exp_q.push_back(build);
        build     = '0;
        build_idx = 4'd0;
      end else begin
        build_idx = build_idx + 4'd1;
      end
    end
    word_valid_in   = v;
    word_in         = w;
    word_last_in    = l;
    blocks_ready_in = r;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst             = 1'b1;
    word_valid_in   = 1'b0;
    word_in         = 8'h00;
    word_last_in    = 1'b0;
    blocks_ready_in = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    reset_model();
  endtask

  task automatic test_reset();
    rst             = 1'b1;
    word_valid_in   = 1'b0;
    word_in         = 8'h00;
    word_last_in    = 1'b0;
    blocks_ready_in = 1'b0;
    @(posedge clk);
    @(negedge clk);
    vectors++;
    if (blocks_valid_out !== 1'b0 || blocks_out !== '0 || frame_count_out !== 16'd0) begin
      miscompares++;
      $display("[TB] FAIL reset_outputs: got vld=%b blk=%h cnt=%0d, want 0/0/0",
               blocks_valid_out, blocks_out, frame_count_out);
    end
    rst = 1'b0;
    reset_model();
    for (int c = 0; c < 2; c++) begin
      tick(1'b0, 8'h00, 1'b0, 1'b1);
      vectors++;
      if (obs_ready !== 1'b1 || obs_valid !== 1'b0 || obs_count !== 16'd0) begin
        miscompares++;
        $display("[TB] FAIL reset_idle c%0d: got rdy=%b vld=%b cnt=%0d, want 1/0/0",
                 c, obs_ready, obs_valid, obs_count);
      end
    end
  endtask

  task automatic test_basic_fill();
    do_reset();
    for (int c = 0; c < 18; c++) begin
      tick(c < 16, 8'(c), 1'b0, 1'b1);
      vectors++;
      if (obs_ready !== exp_ready || obs_valid !== exp_valid || obs_count !== exp_cnt) begin
        miscompares++;
        $display("[TB] FAIL basic_hs c%0d: got rdy=%b vld=%b cnt=%0d, want rdy=%b vld=%b cnt=%0d",
                 c, obs_ready, obs_valid, obs_count, exp_ready, exp_valid, exp_cnt);
      end
      if (exp_valid) begin
        vectors++;
        if (obs_blocks !== exp_head) begin
          miscompares++;
          $display("[TB] FAIL basic_data c%0d: got %h want %h", c, obs_blocks, exp_head);
        end
      end
    end
    vectors++;
    if (frame_count_out !== 16'd1) begin
      miscompares++;
      $display("[TB] FAIL basic_count: got %0d want 1", frame_count_out);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int c = 0; c < 50; c++) begin
      tick(c < 48, 8'(c), 1'b0, 1'b1);
      vectors++;
      if (obs_ready !== exp_ready || obs_valid !== exp_valid || obs_count !== exp_cnt) begin
        miscompares++;
        $display("[TB] FAIL b2b_hs c%0d: got rdy=%b vld=%b cnt=%0d, want rdy=%b vld=%b cnt=%0d",
                 c, obs_ready, obs_valid, obs_count, exp_ready, exp_valid, exp_cnt);
      end
      if (exp_valid) begin
        vectors++;
        if (obs_blocks !== exp_head) begin
          miscompares++;
          $display("[TB] FAIL b2b_data c%0d: got %h want %h", c, obs_blocks, exp_head);
        end
      end
    end
    vectors++;
    if (frame_count_out !== 16'd3) begin
      miscompares++;
      $display("[TB] FAIL b2b_count: got %0d want 3", frame_count_out);
    end
  endtask

  task automatic test_backpressure();
    int sent;
    sent = 0;
    do_reset();
    for (int c = 0; c < 60; c++) begin
      tick(sent < 40, 8'(sent), sent == 39, (c == 36) || (c >= 50));
      if (last_acc) sent++;
      vectors++;
      if (obs_ready !== exp_ready || obs_valid !== exp_valid || obs_count !== exp_cnt) begin
        miscompares++;
        $display("[TB] FAIL bp_hs c%0d: got rdy=%b vld=%b cnt=%0d, want rdy=%b vld=%b cnt=%0d",
                 c, obs_ready, obs_valid, obs_count, exp_ready, exp_valid, exp_cnt);
      end
      if (exp_valid) begin
        vectors++;
        if (obs_blocks !== exp_head) begin
          miscompares++;
          $display("[TB] FAIL bp_data c%0d: got %h want %h", c, obs_blocks, exp_head);
        end
      end
    end
    vectors++;
    if (frame_count_out !== 16'd3 || sent != 40) begin
      miscompares++;
      $display("[TB] FAIL bp_count: got cnt=%0d sent=%0d want cnt=3 sent=40", frame_count_out, sent);
    end
  endtask

  task automatic test_early_last();
    logic [7:0] w;
    do_reset();
    for (int c = 0; c < 57; c++) begin
      if (c < 16)      w = 8'hC0 + 8'(c);
      else if (c < 32) w = 8'hE0 + 8'(c - 16);
      else if (c < 38) w = 8'hA0 + 8'(c - 32);
      else             w = 8'h10 + 8'(c - 38);
      tick(c < 54, w, c == 37, 1'b1);
      vectors++;
      if (obs_ready !== exp_ready || obs_valid !== exp_valid || obs_count !== exp_cnt) begin
        miscompares++;
        $display("[TB] FAIL early_hs c%0d: got rdy=%b vld=%b cnt=%0d, want rdy=%b vld=%b cnt=%0d",
                 c, obs_ready, obs_valid, obs_count, exp_ready, exp_valid, exp_cnt);
      end
      if (exp_valid) begin
        vectors++;
        if (obs_blocks !== exp_head) begin
          miscompares++;
          $display("[TB] FAIL early_data c%0d: got %h want %h", c, obs_blocks, exp_head);
        end
      end
    end
    vectors++;
    if (frame_count_out !== 16'd4) begin
      miscompares++;
      $display("[TB] FAIL early_count: got %0d want 4", frame_count_out);
    end
  endtask

  task automatic test_simultaneous();
    logic v;
    logic r;
    do_reset();
    for (int c = 0; c < 36; c++) begin
      v = (c < 32);
      r = (c == 31) || (c >= 33);
      tick(v, (c < 16) ? 8'h40 + 8'(c) : 8'h60 + 8'(c - 16), 1'b0, r);
      vectors++;
      if (obs_ready !== exp_ready || obs_valid !== exp_valid || obs_count !== exp_cnt) begin
        miscompares++;
        $display("[TB] FAIL simul_hs c%0d: got rdy=%b vld=%b cnt=%0d, want rdy=%b vld=%b cnt=%0d",
                 c, obs_ready, obs_valid, obs_count, exp_ready, exp_valid, exp_cnt);
      end
      if (exp_valid) begin
        vectors++;
        if (obs_blocks !== exp_head) begin
          miscompares++;
          $display("[TB] FAIL simul_data c%0d: got %h want %h", c, obs_blocks, exp_head);
        end
      end
    end
    vectors++;
    if (frame_count_out !== 16'd2) begin
      miscompares++;
      $display("[TB] FAIL simul_count: got %0d want 2", frame_count_out);
    end
  endtask

  task automatic test_async_reset();
    logic [7:0] w;
    do_reset();
    for (int c = 0; c < 40; c++) begin
      if (c < 16)      w = 8'h80 + 8'(c);
      else if (c < 33) w = 8'h90 + 8'(c - 17);
      else             w = 8'hB0 + 8'(c - 33);
      tick(c != 16, w, 1'b0, c <= 16);
      vectors++;
      if (obs_ready !== exp_ready || obs_valid !== exp_valid || obs_count !== exp_cnt) begin
        miscompares++;
        $display("[TB] FAIL arst_pre_hs c%0d: got rdy=%b vld=%b cnt=%0d, want rdy=%b vld=%b cnt=%0d",
                 c, obs_ready, obs_valid, obs_count, exp_ready, exp_valid, exp_cnt);
      end
      if (exp_valid) begin
        vectors++;
        if (obs_blocks !== exp_head) begin
          miscompares++;
          $display("[TB] FAIL arst_pre_data c%0d: got %h want %h", c, obs_blocks, exp_head);
        end
      end
    end
    word_valid_in   = 1'b0;
    blocks_ready_in = 1'b0;
    rst = 1'b1;
    #1;
    vectors++;
    if (blocks_valid_out !== 1'b0 || blocks_out !== '0 || frame_count_out !== 16'd0 ||
        word_ready_out !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL arst_immediate: got vld=%b blk=%h cnt=%0d rdy=%b, want 0/0/0/1",
               blocks_valid_out, blocks_out, frame_count_out, word_ready_out);
    end
    @(negedge clk);
    rst = 1'b0;
    reset_model();
    for (int c = 0; c < 18; c++) begin
      tick(c < 16, 8'hD0 + 8'(c), 1'b0, 1'b1);
      vectors++;
      if (obs_ready !== exp_ready || obs_valid !== exp_valid || obs_count !== exp_cnt) begin
        miscompares++;
        $display("[TB] FAIL arst_post_hs c%0d: got rdy=%b vld=%b cnt=%0d, want rdy=%b vld=%b cnt=%0d",
                 c, obs_ready, obs_valid, obs_count, exp_ready, exp_valid, exp_cnt);
      end
      if (exp_valid) begin
        vectors++;
        if (obs_blocks !== exp_head) begin
          miscompares++;
          $display("[TB] FAIL arst_post_data c%0d: got %h want %h", c, obs_blocks, exp_head);
        end
      end
    end
    vectors++;
    if (frame_count_out !== 16'd1) begin
      miscompares++;
      $display("[TB] FAIL arst_count: got %0d want 1", frame_count_out);
    end
  endtask

  initial begin
    reset_model();
    test_reset();
    test_basic_fill();
    test_back_to_back();
    test_backpressure();
    test_early_last();
    test_simultaneous();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
